pio_in_edge_irq: RTL

// - Parametrised Avalon-MM input PIO for Nios II peripheral slots: synchronises a DATA_WIDTH-bit external input bus.
// - Detects per-bit edges into a sticky edge-capture register.
// - Raises a maskable interrupt to the CPU.
// - Next generation of the fixed 8-bit read-only input port; adds the standard PIO register map, edge capture and IRQ.

---
 rtl/pio_pkg.sv | 21 ++
 rtl/pio_in_edge_irq_if.sv | 22 ++
 rtl/pio_sync_edge.sv | 69 ++++++
 rtl/pio_in_edge_irq.sv | 74 +++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared definitions for the PIO family: register map, edge and IRQ mode codes.
package pio_pkg;

   localparam int unsigned PIO_ADDR_W = 2;
   localparam int unsigned PIO_BUS_W  = 32;

   typedef enum logic [PIO_ADDR_W-1:0] {
      PIO_OFS_DATA = 2'd0,
      PIO_OFS_DIR  = 2'd1,
      PIO_OFS_MASK = 2'd2,
      PIO_OFS_EDGE = 2'd3
   } pio_ofs_e;

   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_ANY  = 2;

   localparam int unsigned IRQ_LEVEL = 0;
   localparam int unsigned IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave port of the input PIO, including its interrupt line.
interface pio_in_edge_irq_if;
   import pio_pkg::*;

   logic [PIO_ADDR_W-1:0] address;
   logic                  chipselect;
   logic                  write_n;
   logic [PIO_BUS_W-1:0]  writedata;
   logic [PIO_BUS_W-1:0]  readdata;
   logic                  irq;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq
   );

endinterface

// File: rtl/pio_sync_edge.sv
// Input synchroniser, previous-value register and post-reset arm gate feeding
// a per-bit edge vector of the selected polarity.
module pio_sync_edge
   import pio_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [DATA_WIDTH-1:0] sync_data,
   output logic [DATA_WIDTH-1:0] edge_vec
);

   localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;

   logic [DATA_WIDTH-1:0] prev;
   logic [DATA_WIDTH-1:0] rise;
   logic [DATA_WIDTH-1:0] fall;
   logic [DATA_WIDTH-1:0] edge_sel;
   logic [2:0]            arm_cnt;
   logic                  armed;

   // Shift chain: newest sample at the LSB slice, synchronised output at the MSB slice.
   if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_data = in_port;
   end else begin : g_sync
      logic [SYNC_STAGES*DATA_WIDTH-1:0] chain;
      logic [SYNC_STAGES*DATA_WIDTH-1:0] chain_d;

      if (SYNC_STAGES == 1) begin : g_one
         assign chain_d = in_port;
      end else begin : g_many
         assign chain_d = {chain[(SYNC_STAGES-1)*DATA_WIDTH-1:0], in_port};
      end

      always_ff @(posedge clk) begin
         if (!reset_n) chain <= '0;
         else          chain <= chain_d;
      end

      assign sync_data = chain[SYNC_STAGES*DATA_WIDTH-1 -: DATA_WIDTH];
   end

   assign armed = (arm_cnt == 3'(ARM_CYCLES));

   // Arm counter hides the reset-cleared chain filling up with inputs held high.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prev    <= '0;
         arm_cnt <= '0;
      end else begin
         prev <= sync_data;
         if (!armed) arm_cnt <= arm_cnt + 3'd1;
      end
   end

   always_comb begin
      rise     = sync_data & ~prev;
      fall     = ~sync_data & prev;
      edge_sel = rise;
      if (EDGE_TYPE == EDGE_FALL)     edge_sel = fall;
      else if (EDGE_TYPE == EDGE_ANY) edge_sel = rise | fall;
      edge_vec = armed ? edge_sel : '0;
   end

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO with sticky edge capture, interrupt mask and maskable IRQ.
module pio_in_edge_irq
   import pio_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned EDGE_TYPE    = EDGE_RISE,
   parameter int unsigned IRQ_TYPE     = IRQ_EDGE,
   parameter int unsigned BIT_CLEARING = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   pio_in_edge_irq_if.slave      bus,
   input  logic [DATA_WIDTH-1:0] in_port
);

   logic [DATA_WIDTH-1:0] sync_data;
   logic [DATA_WIDTH-1:0] edge_vec;
   logic [DATA_WIDTH-1:0] mask;
   logic [DATA_WIDTH-1:0] edgecapture;
   logic [DATA_WIDTH-1:0] clr_vec;
   logic [PIO_BUS_W-1:0]  rd_next;
   logic                  wr_en;
   logic                  unused_wdata;

   pio_sync_edge #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_sync_edge (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_port   (in_port),
      .sync_data (sync_data),
      .edge_vec  (edge_vec)
   );

   assign wr_en        = bus.chipselect & ~bus.write_n;
   assign unused_wdata = ^bus.writedata;

   // Clear vector for edgecapture; new edges are OR-ed in afterwards so they win.
   always_comb begin
      clr_vec = '0;
      if (wr_en && (bus.address == PIO_OFS_EDGE)) begin
         if (BIT_CLEARING != 0) clr_vec = bus.writedata[DATA_WIDTH-1:0];
         else                   clr_vec = '1;
      end
   end

   always_comb begin
      rd_next = '0;
      case (bus.address)
         PIO_OFS_DATA: rd_next = PIO_BUS_W'(sync_data);
         PIO_OFS_MASK: rd_next = PIO_BUS_W'(mask);
         PIO_OFS_EDGE: rd_next = PIO_BUS_W'(edgecapture);
         default:      rd_next = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mask         <= '0;
         edgecapture  <= '0;
         bus.readdata <= '0;
      end else begin
         if (wr_en && (bus.address == PIO_OFS_MASK)) mask <= bus.writedata[DATA_WIDTH-1:0];
         edgecapture  <= (edgecapture & ~clr_vec) | edge_vec;
         bus.readdata <= rd_next;
      end
   end

   assign bus.irq = (IRQ_TYPE == IRQ_EDGE) ? |(edgecapture & mask) : |(sync_data & mask);

endmodule
